// File: rtl/i2c_sched_pkg.sv
// Shared types and constants for the ADT7420 I2C transaction scheduler.
package i2c_sched_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARB   = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    RETRY = 3'd4,
    DONE  = 3'd5
  } state_t;

  typedef enum logic {
    GNT_HOST = 1'b0,
    GNT_POLL = 1'b1
  } grant_t;

  localparam logic [6:0]  ADT7420_ADDR     = 7'h48;
  localparam logic [7:0]  ADT7420_TEMP_REG = 8'h00;
  localparam int unsigned POLL_CNT_W       = 32;

endpackage

// File: rtl/i2c_txn_scheduler_poll_timer.sv
// Free-running poll period counter; raises poll_pend at each wrap, at most one queued.
module i2c_poll_timer
  import i2c_sched_pkg::*;
#(
  parameter int unsigned POLL_PERIOD = 100_000
) (
  input  logic clk,
  input  logic rst,
  input  logic poll_clr,
  output logic poll_pend
);

  logic [POLL_CNT_W-1:0] cnt;
  logic                  wrap;

  assign wrap = (POLL_PERIOD != 0) && (cnt == POLL_PERIOD - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      poll_pend <= 1'b0;
    end else begin
      if (POLL_PERIOD == 0 || wrap) cnt <= '0;
      else                          cnt <= cnt + 1'b1;

      // A wrap arriving while a poll is still queued is discarded.
      if (wrap && !poll_pend) poll_pend <= 1'b1;
      else if (poll_clr)      poll_pend <= 1'b0;
    end
  end

endmodule

// File: rtl/i2c_txn_scheduler.sv
// Shares the ADT7420 byte engine between host commands and a periodic temperature poll,
// with NACK retry, hung-bus timeout and latched temperature.
module i2c_txn_scheduler
  import i2c_sched_pkg::*;
#(
  parameter int unsigned POLL_PERIOD = 100_000,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned TIMEOUT     = 4096,
  parameter logic [6:0]  DEV_ADDR    = ADT7420_ADDR,
  parameter logic [7:0]  TEMP_REG    = ADT7420_TEMP_REG
) (
  input  logic        FSM_Clk,
  input  logic        reset,
  input  logic        host_req,
  input  logic        host_rw,
  input  logic [7:0]  host_reg,
  input  logic [7:0]  host_wdata,
  output logic        host_done,
  output logic [15:0] host_rdata,
  output logic        eng_valid,
  input  logic        eng_ready,
  output logic        eng_rw,
  output logic [6:0]  eng_dev,
  output logic [7:0]  eng_reg,
  output logic [7:0]  eng_wdata,
  input  logic        eng_done,
  input  logic        eng_nack,
  input  logic [15:0] eng_rdata,
  output logic [12:0] temp,
  output logic        temp_valid,
  output logic        error,
  output logic        busy,
  output logic [7:0]  State
);

  state_t      state;
  grant_t      grant, last_grant;
  logic        host_req_q, host_pend, poll_pend, poll_clr;
  logic [31:0] retry_cnt, to_cnt;
  logic [15:0] rdata_q;
  logic        fail_q;

  assign busy     = (state != IDLE);
  assign State    = {5'b0, state};
  assign poll_clr = (state == DONE) && (grant == GNT_POLL);

  i2c_poll_timer #(.POLL_PERIOD(POLL_PERIOD)) u_poll_timer (
    .clk       (FSM_Clk),
    .rst       (reset),
    .poll_clr  (poll_clr),
    .poll_pend (poll_pend)
  );

  always_ff @(posedge FSM_Clk or posedge reset) begin
    if (reset) begin
      host_req_q <= 1'b0;
      host_pend  <= 1'b0;
    end else begin
      host_req_q <= host_req;
      if (host_req && !host_req_q && !host_pend)    host_pend <= 1'b1;
      else if (state == DONE && grant == GNT_HOST)  host_pend <= 1'b0;
    end
  end

  always_ff @(posedge FSM_Clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= GNT_POLL;
      last_grant <= GNT_POLL;
      retry_cnt  <= '0;
      to_cnt     <= '0;
      rdata_q    <= '0;
      fail_q     <= 1'b0;
      host_done  <= 1'b0;
      host_rdata <= '0;
      eng_valid  <= 1'b0;
      eng_rw     <= 1'b0;
      eng_dev    <= '0;
      eng_reg    <= '0;
      eng_wdata  <= '0;
      temp       <= '0;
      temp_valid <= 1'b0;
      error      <= 1'b0;
    end else begin
      host_done <= 1'b0;
      case (state)
        IDLE: if (host_pend || poll_pend) state <= ARB;
        ARB: begin
          // With both pending, the requester not served last time wins.
          if (host_pend && (!poll_pend || last_grant == GNT_POLL)) begin
            grant      <= GNT_HOST;
            last_grant <= GNT_HOST;
            eng_rw     <= host_rw;
            eng_reg    <= host_reg;
            eng_wdata  <= host_wdata;
          end else begin
            grant      <= GNT_POLL;
            last_grant <= GNT_POLL;
            eng_rw     <= 1'b1;
            eng_reg    <= TEMP_REG;
            eng_wdata  <= '0;
          end
          eng_dev   <= DEV_ADDR;
          retry_cnt <= '0;
          to_cnt    <= '0;
          eng_valid <= 1'b1;
          state     <= ISSUE;
        end
        ISSUE: begin
          if (eng_valid && eng_ready) begin
            eng_valid <= 1'b0;
            to_cnt    <= '0;
            state     <= WAIT;
          end else if (to_cnt == TIMEOUT - 1) begin
            eng_valid <= 1'b0;
            fail_q    <= 1'b1;
            rdata_q   <= '0;
            state     <= DONE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        WAIT: begin
          if (eng_done && !eng_nack) begin
            fail_q  <= 1'b0;
            rdata_q <= eng_rdata;
            state   <= DONE;
          end else if (eng_done && retry_cnt < MAX_RETRY) begin
            state <= RETRY;
          end else if (eng_done || to_cnt == TIMEOUT - 1) begin
            fail_q  <= 1'b1;
            rdata_q <= '0;
            state   <= DONE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        RETRY: begin
          retry_cnt <= retry_cnt + 1'b1;
          to_cnt    <= '0;
          eng_valid <= 1'b1;
          state     <= ISSUE;
        end
        DONE: begin
          error <= fail_q;
          if (grant == GNT_HOST) begin
            host_done  <= 1'b1;
            host_rdata <= rdata_q;
          end else if (!fail_q) begin
            temp       <= rdata_q[15:3];
            temp_valid <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_txn_scheduler.sv
// Scoreboard bench: behavioural byte engine, host-completion and grant-order queues.
module tb_i2c_txn_scheduler;
  import i2c_sched_pkg::*;

  localparam int unsigned PERIOD  = 200;
  localparam int unsigned RETRIES = 3;
  localparam int unsigned TMO     = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        host_req, host_rw, host_done;
  logic [7:0]  host_reg, host_wdata;
  logic [15:0] host_rdata;
  logic        eng_valid, eng_ready, eng_rw, eng_done, eng_nack;
  logic [6:0]  eng_dev;
  logic [7:0]  eng_reg, eng_wdata;
  logic [15:0] eng_rdata;
  logic [12:0] temp;
  logic        temp_valid, error, busy;
  logic [7:0]  State;

  always #5 clk = ~clk;

  i2c_txn_scheduler #(.POLL_PERIOD(PERIOD), .MAX_RETRY(RETRIES), .TIMEOUT(TMO)) dut (
    .FSM_Clk(clk), .reset(rst),
    .host_req(host_req), .host_rw(host_rw), .host_reg(host_reg), .host_wdata(host_wdata),
    .host_done(host_done), .host_rdata(host_rdata),
    .eng_valid(eng_valid), .eng_ready(eng_ready), .eng_rw(eng_rw), .eng_dev(eng_dev),
    .eng_reg(eng_reg), .eng_wdata(eng_wdata), .eng_done(eng_done), .eng_nack(eng_nack),
    .eng_rdata(eng_rdata), .temp(temp), .temp_valid(temp_valid), .error(error),
    .busy(busy), .State(State)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned cyc;
  bit          eng_hang = 1'b0;
  int          nack_left = 0;
  int          hs_total = 0;
  int          host_done_seen = 0;
  int unsigned last_valid_cyc, last_hs_cyc;
  int unsigned poll_hs[$];
  logic [7:0]  exp_order[$];
  logic [15:0] exp_host[$];
  logic        prev_host_done = 1'b0;

  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Byte engine: accepts at once, answers two cycles after the handshake.
  initial begin
    logic [7:0] cur_reg;
    eng_ready = 1'b1; eng_done = 1'b0; eng_nack = 1'b0; eng_rdata = '0;
    forever begin
      @(negedge clk);
      eng_done = 1'b0; eng_nack = 1'b0;
      if (!rst && eng_valid && eng_ready) begin
        hs_total++;
        last_valid_cyc = cyc;
        last_hs_cyc    = cyc + 1;
        check_eq("eng_dev", eng_dev, 7'h48);
        if (eng_reg == 8'h00 && eng_rw) poll_hs.push_back(cyc + 1);
        if (exp_order.size() > 0) check_eq("grant_order", eng_reg, exp_order.pop_front());
        if (!eng_hang) begin
          cur_reg = eng_reg;
          repeat (2) @(negedge clk);
          eng_done  = 1'b1;
          eng_nack  = (nack_left > 0);
          if (nack_left > 0) nack_left--;
          eng_rdata = (cur_reg == 8'h00) ? 16'h0C80 : 16'hCB00;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && eng_valid) check_eq("valid_only_in_issue", State, 8'(ISSUE));
    if (!rst && host_done) begin
      host_done_seen++;
      check_eq("host_done_pulse", prev_host_done, 1'b0);
      if (exp_host.size() == 0) check_eq("host_done_unexpected", exp_host.size(), 1);
      else                      check_eq("host_rdata", host_rdata, exp_host.pop_front());
    end
    prev_host_done = host_done;
  end

  task automatic host_cmd(input logic rw, input logic [7:0] r, input logic [7:0] wd);
    host_rw = rw; host_reg = r; host_wdata = wd; host_req = 1'b1;
    repeat (2) @(negedge clk);
    host_req = 1'b0;
  endtask

  task automatic wait_polls(input string tag, input int n);
    int k = 0;
    while (poll_hs.size() < n && k < 400) begin @(negedge clk); k++; end
    check_eq(tag, poll_hs.size(), n);
  endtask

  task automatic wait_hs(input string tag, input int n);
    int k = 0;
    while (hs_total < n && k < 200) begin @(negedge clk); k++; end
    check_eq(tag, hs_total, n);
  endtask

  task automatic wait_hdone(input string tag, input int n);
    int k = 0;
    while (host_done_seen < n && k < 300) begin @(negedge clk); k++; end
    check_eq(tag, host_done_seen, n);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < 300) begin @(negedge clk); k++; end
    check_eq(tag, busy, 1'b0);
  endtask

  task automatic wait_state(input string tag, input logic [7:0] s);
    int k = 0;
    while (State != s && k < 200) begin @(negedge clk); k++; end
    check_eq(tag, State, s);
  endtask

  task automatic wait_cyc(input string tag, input int unsigned t);
    int k = 0;
    while (cyc < t && k < 1000) begin @(negedge clk); k++; end
    check_eq(tag, cyc, t);
  endtask

  initial begin
    int unsigned n0;
    int          h0, d0;
    rst = 1'b1; host_req = 1'b0; host_rw = 1'b0; host_reg = '0; host_wdata = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_eng_valid", eng_valid, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_state", State, 8'(IDLE));
    check_eq("rst_temp_valid", temp_valid, 1'b0);
    check_eq("rst_temp", temp, 13'h0);
    check_eq("rst_error", error, 1'b0);
    check_eq("rst_host_done", host_done, 1'b0);
    check_eq("rst_host_rdata", host_rdata, 16'h0);
    rst = 1'b0;

    wait_polls("poll1_seen", 1);
    check_eq("poll1_cycle", poll_hs[0], 203);
    wait_idle("poll1_idle");
    check_eq("poll1_temp", temp, 13'h190);
    check_eq("poll1_temp_valid", temp_valid, 1'b1);
    check_eq("poll1_error", error, 1'b0);
    wait_polls("poll2_seen", 2);
    check_eq("poll_period", poll_hs[1] - poll_hs[0], PERIOD);
    wait_idle("poll2_idle");

    h0 = hs_total; d0 = host_done_seen; n0 = cyc;
    exp_host.push_back(16'hCB00);
    host_cmd(1'b1, 8'h0B, 8'h00);
    wait_hs("host_rd_hs", h0 + 1);
    check_eq("host_turnaround", last_valid_cyc - n0, 3);
    wait_hdone("host_rd_done", d0 + 1);
    check_eq("host_rd_error", error, 1'b0);

    h0 = hs_total; d0 = host_done_seen; nack_left = 2;
    exp_host.push_back(16'hCB00);
    host_cmd(1'b1, 8'h0C, 8'h00);
    wait_hdone("nack2_done", d0 + 1);
    check_eq("nack2_issues", hs_total - h0, 3);
    check_eq("nack2_error", error, 1'b0);

    h0 = hs_total; d0 = host_done_seen; nack_left = 4;
    exp_host.push_back(16'h0000);
    host_cmd(1'b1, 8'h0C, 8'h00);
    wait_hdone("nack4_done", d0 + 1);
    check_eq("nack4_issues", hs_total - h0, 4);
    check_eq("nack4_error", error, 1'b1);

    wait_polls("poll3_seen", 3);
    wait_idle("poll3_idle");
    check_eq("error_cleared_by_poll", error, 1'b0);

    h0 = hs_total; d0 = host_done_seen; eng_hang = 1'b1;
    exp_host.push_back(16'h0000);
    host_cmd(1'b1, 8'h0D, 8'h00);
    wait_hs("tmo_hs", h0 + 1);
    wait_state("tmo_reach_done", 8'(DONE));
    check_eq("tmo_cycles", cyc - last_hs_cyc, TMO);
    eng_hang = 1'b0;
    wait_hdone("tmo_host_done", d0 + 1);
    check_eq("tmo_error", error, 1'b1);
    wait_idle("tmo_idle");

    wait_polls("poll4_seen", 4);
    wait_idle("poll4_idle");
    exp_order.push_back(8'h01); exp_order.push_back(8'h00);
    exp_host.push_back(16'hCB00);
    wait_cyc("sync_wrap5", 5 * PERIOD - 1);
    host_cmd(1'b1, 8'h01, 8'h00);
    wait_polls("poll5_seen", 5);
    wait_idle("arb1_idle");
    check_eq("arb1_order_drained", exp_order.size(), 0);

    exp_order.push_back(8'h03); exp_order.push_back(8'h00); exp_order.push_back(8'h04);
    exp_host.push_back(16'hCB00); exp_host.push_back(16'hCB00);
    wait_cyc("sync_host3", 6 * PERIOD - 30);
    host_cmd(1'b1, 8'h03, 8'h00);
    wait_cyc("sync_wrap6", 6 * PERIOD - 1);
    host_cmd(1'b1, 8'h04, 8'h00);
    wait_polls("poll6_seen", 6);
    wait_hdone("arb2_done", host_done_seen + 1);
    wait_idle("arb2_idle");
    check_eq("arb2_order_drained", exp_order.size(), 0);
    check_eq("host_sb_drained", exp_host.size(), 0);

    eng_hang = 1'b1;
    host_cmd(1'b1, 8'h0E, 8'h00);
    wait_state("rst_reach_wait", 8'(WAIT));
    #2 rst = 1'b1;
    #1;
    check_eq("midrst_eng_valid", eng_valid, 1'b0);
    check_eq("midrst_busy", busy, 1'b0);
    check_eq("midrst_state", State, 8'(IDLE));
    check_eq("midrst_temp_valid", temp_valid, 1'b0);
    eng_hang = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    wait_polls("poll_restart_seen", 7);
    check_eq("poll_restart_cycle", poll_hs[6], 203);
    wait_idle("poll_restart_idle");
    check_eq("poll_restart_temp_valid", temp_valid, 1'b1);
    check_eq("poll_restart_temp", temp, 13'h190);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
